// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between the DMA engine and the cache path, with per-read return routing.
// Optional `BRAM_ARB_DMA_BURST_EN` lets the DMA hold the grant for up to BURST_LEN accesses under contention.
module bram_port_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 2,
  parameter int BURST_LEN = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              dma_req_valid,
  input  logic              dma_req_we,
  input  logic [ADDR_W-1:0] dma_req_addr,
  input  logic [DATA_W-1:0] dma_req_wdata,
  output logic              dma_req_ack,
  output logic              dma_rdata_valid,
  output logic [DATA_W-1:0] dma_rdata,
  input  logic              cc_req_valid,
  input  logic              cc_req_we,
  input  logic [ADDR_W-1:0] cc_req_addr,
  input  logic [DATA_W-1:0] cc_req_wdata,
  output logic              cc_req_ack,
  output logic              cc_rdata_valid,
  output logic [DATA_W-1:0] cc_rdata,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  logic              last_cc_r;
  logic              dma_gnt_s;
  logic              cc_gnt_s;
  logic              burst_ok_s;
  logic              rd_issue_s;
  logic [RD_LAT-1:0] tag_v_r;
  logic [RD_LAT-1:0] tag_cc_r;
  logic              tag_out_v_s;
  logic              tag_out_cc_s;

`ifdef BRAM_ARB_DMA_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  logic [CNT_W-1:0] burst_cnt_r;

  assign burst_ok_s = (burst_cnt_r < CNT_W'(BURST_LEN));

  // Count consecutive DMA grants; saturates so long DMA-only runs still yield to the cache.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      burst_cnt_r <= {CNT_W{1'b0}};
    end else if (dma_gnt_s) begin
      burst_cnt_r <= burst_ok_s ? burst_cnt_r + CNT_W'(1) : burst_cnt_r;
    end else begin
      burst_cnt_r <= {CNT_W{1'b0}};
    end
  end
`else
  // Without the burst option this is constant false: plain alternation under contention.
  assign burst_ok_s = (BURST_LEN < 0) ? 1'b1 : 1'b0;
`endif

  // Grant selection: sole requester wins; on conflict the one not granted last wins.
  always_comb begin
    dma_gnt_s = 1'b0;
    cc_gnt_s  = 1'b0;
    if (dma_req_valid && cc_req_valid) begin
      if (last_cc_r || burst_ok_s) begin
        dma_gnt_s = 1'b1;
      end else begin
        cc_gnt_s = 1'b1;
      end
    end else begin
      dma_gnt_s = dma_req_valid;
      cc_gnt_s  = cc_req_valid;
    end
  end

  assign dma_req_ack = dma_gnt_s;
  assign cc_req_ack  = cc_gnt_s;
  assign bram_en     = dma_gnt_s | cc_gnt_s;
  assign rd_issue_s  = (dma_gnt_s & ~dma_req_we) | (cc_gnt_s & ~cc_req_we);

  // BRAM port mux from the granted requester.
  always_comb begin
    bram_we    = 1'b0;
    bram_addr  = dma_req_addr;
    bram_wdata = dma_req_wdata;
    if (cc_gnt_s) begin
      bram_we    = cc_req_we;
      bram_addr  = cc_req_addr;
      bram_wdata = cc_req_wdata;
    end else if (dma_gnt_s) begin
      bram_we = dma_req_we;
    end else begin
      bram_we = 1'b0;
    end
  end

  // Remember who was granted last for fairness on the next conflict.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      last_cc_r <= 1'b1;
    end else if (dma_gnt_s) begin
      last_cc_r <= 1'b0;
    end else if (cc_gnt_s) begin
      last_cc_r <= 1'b1;
    end else begin
      last_cc_r <= last_cc_r;
    end
  end

  // Tag shift register tracking {valid, owner} of each read through the BRAM latency.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      tag_v_r  <= {RD_LAT{1'b0}};
      tag_cc_r <= {RD_LAT{1'b0}};
    end else begin
      tag_v_r[0]  <= rd_issue_s;
      tag_cc_r[0] <= cc_gnt_s;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v_r[i]  <= tag_v_r[i-1];
        tag_cc_r[i] <= tag_cc_r[i-1];
      end
    end
  end

  assign tag_out_v_s  = tag_v_r[RD_LAT-1];
  assign tag_out_cc_s = tag_cc_r[RD_LAT-1];

  // Register returning BRAM data into the owning requester's output and pulse its valid.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      dma_rdata_valid <= 1'b0;
      cc_rdata_valid  <= 1'b0;
      dma_rdata       <= {DATA_W{1'b0}};
      cc_rdata        <= {DATA_W{1'b0}};
    end else begin
      dma_rdata_valid <= tag_out_v_s & ~tag_out_cc_s;
      cc_rdata_valid  <= tag_out_v_s & tag_out_cc_s;
      if (tag_out_v_s && !tag_out_cc_s) begin
        dma_rdata <= bram_rdata;
      end else begin
        dma_rdata <= dma_rdata;
      end
      if (tag_out_v_s && tag_out_cc_s) begin
        cc_rdata <= bram_rdata;
      end else begin
        cc_rdata <= cc_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomised and directed bench for bram_port_arbiter with a BRAM model and a transaction-level reference.
module tb_bram_port_arbiter;
  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 32;
  localparam int RD_LAT    = 2;
  localparam int BURST_LEN = 4;
  localparam int DEPTH     = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              dma_req_valid, dma_req_we, dma_req_ack, dma_rdata_valid;
  logic [ADDR_W-1:0] dma_req_addr;
  logic [DATA_W-1:0] dma_req_wdata, dma_rdata;
  logic              cc_req_valid, cc_req_we, cc_req_ack, cc_rdata_valid;
  logic [ADDR_W-1:0] cc_req_addr;
  logic [DATA_W-1:0] cc_req_wdata, cc_rdata;
  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata, bram_rdata;

  bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .BURST_LEN(BURST_LEN)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .dma_req_valid(dma_req_valid), .dma_req_we(dma_req_we), .dma_req_addr(dma_req_addr),
    .dma_req_wdata(dma_req_wdata), .dma_req_ack(dma_req_ack),
    .dma_rdata_valid(dma_rdata_valid), .dma_rdata(dma_rdata),
    .cc_req_valid(cc_req_valid), .cc_req_we(cc_req_we), .cc_req_addr(cc_req_addr),
    .cc_req_wdata(cc_req_wdata), .cc_req_ack(cc_req_ack),
    .cc_rdata_valid(cc_rdata_valid), .cc_rdata(cc_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  function automatic logic [31:0] init_word(int a);
    if (a == 16) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  // BRAM model: write-first, read data appears RD_LAT cycles after the sampled strobe.
  logic [31:0] bmem [DEPTH];
  logic [31:0] rpipe [RD_LAT];
  logic        init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < DEPTH; i++) bmem[i] <= init_word(i);
      init_done <= 1'b1;
    end else if (bram_en && bram_we) begin
      bmem[bram_addr] <= bram_wdata;
    end
    rpipe[0] <= (bram_en && bram_we) ? bram_wdata : bmem[bram_addr];
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bram_rdata = rpipe[RD_LAT-1];

  // Reference model state: memory image, last winner, DMA run length, outstanding reads.
  typedef struct {
    int          due;
    bit          own_cc;
    logic [31:0] data;
  } rd_t;
  logic [31:0] mmem [DEPTH];
  rd_t         pend [$];
  int          m_last;
  int          m_burst;
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          obs_g;
  logic        obs_dv, obs_cv;
  logic [31:0] obs_dd, obs_cd;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_grant();
    if (dma_req_valid && !cc_req_valid) return 1;
    if (cc_req_valid && !dma_req_valid) return 2;
    if (!dma_req_valid) return 0;
    if (m_last == 2) return 1;
`ifdef BRAM_ARB_DMA_BURST_EN
    if (m_burst < BURST_LEN) return 1;
`endif
    return 2;
  endfunction

  // One clock cycle: check every DUT output against the model, then advance the model.
  task automatic cycle();
    int          g;
    logic        ewe, edv, ecv;
    logic [12:0] a;
    logic [31:0] wd, edd, ecd;
    rd_t         e;
    @(negedge clk);
    g   = model_grant();
    ewe = (g == 1) ? dma_req_we : (g == 2) ? cc_req_we : 1'b0;
    a   = (g == 2) ? cc_req_addr : dma_req_addr;
    wd  = (g == 2) ? cc_req_wdata : dma_req_wdata;
    chk("dma_ack", dma_req_ack, (g == 1));
    chk("cc_ack", cc_req_ack, (g == 2));
    chk("bram_en", bram_en, (g != 0));
    chk("bram_we", bram_we, ewe);
    if (g != 0) begin
      chk("bram_addr", bram_addr, a);
      if (ewe) chk("bram_wdata", bram_wdata, wd);
    end
    edv = 1'b0; ecv = 1'b0; edd = 32'h0; ecd = 32'h0;
    foreach (pend[i]) begin
      if (pend[i].due == cyc) begin
        if (pend[i].own_cc) begin ecv = 1'b1; ecd = pend[i].data; end
        else begin edv = 1'b1; edd = pend[i].data; end
      end
    end
    chk("dma_rdata_valid", dma_rdata_valid, edv);
    chk("cc_rdata_valid", cc_rdata_valid, ecv);
    if (edv) chk("dma_rdata", dma_rdata, edd);
    if (ecv) chk("cc_rdata", cc_rdata, ecd);
    obs_g = g; obs_dv = dma_rdata_valid; obs_cv = cc_rdata_valid;
    obs_dd = dma_rdata; obs_cd = cc_rdata;
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    if (g != 0) begin
      if (ewe) mmem[a] = wd;
      else if (rst_n) begin
        e.due = cyc + RD_LAT + 1; e.own_cc = (g == 2); e.data = mmem[a];
        pend.push_back(e);
      end
    end
    if (!rst_n) begin m_last = 2; m_burst = 0; pend.delete(); end
    else if (g == 1) begin m_last = 1; m_burst++; end
    else if (g == 2) begin m_last = 2; m_burst = 0; end
    else m_burst = 0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  int exp_b [10];
  int k;

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; m_last = 2; m_burst = 0;
    for (int i = 0; i < DEPTH; i++) mmem[i] = init_word(i);
    rst_n = 1'b0;
    dma_req_valid = 1'b0; dma_req_we = 1'b0; dma_req_addr = '0; dma_req_wdata = '0;
    cc_req_valid = 1'b0; cc_req_we = 1'b0; cc_req_addr = '0; cc_req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    chk("rst_dma_rdata", dma_rdata, 32'h0);
    chk("rst_cc_rdata", cc_rdata, 32'h0);
    chk("rst_valids", {dma_rdata_valid, cc_rdata_valid}, 32'h0);
    rst_n = 1'b1;

    // DMA-only read of 0x010
    dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = 13'h010;
    cycle();
    chk("A_ack", obs_g, 32'd1);
    dma_req_valid = 1'b0;
    repeat (3) cycle();
    chk("A_valid", obs_dv, 32'd1);
    chk("A_data", obs_dd, 32'hDEAD_BEEF);
    chk("A_cc_quiet", obs_cv, 32'd0);

    // Reads in flight at reset never return
    dma_req_valid = 1'b1; dma_req_addr = 13'h030;
    cycle();
    dma_req_addr = 13'h031;
    cycle();
    dma_req_addr = 13'h032; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; dma_req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("E_no_return", obs_dv, 32'd0);
    end

    // Both streaming reads; first conflict after reset goes to DMA
`ifdef BRAM_ARB_DMA_BURST_EN
    exp_b = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
`else
    exp_b = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2};
`endif
    dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = 13'h000;
    cc_req_valid = 1'b1; cc_req_we = 1'b0; cc_req_addr = 13'h100;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("B_grant", obs_g, exp_b[i]);
      if (i == 3) chk("B_first_dma_data", obs_dd, init_word(0));
      if (obs_g == 1) dma_req_addr = dma_req_addr + 13'd1;
      if (obs_g == 2) cc_req_addr = cc_req_addr + 13'd1;
    end
    dma_req_valid = 1'b0; cc_req_valid = 1'b0;
    repeat (4) cycle();

    // Cache write then DMA read of the same address next cycle
    cc_req_valid = 1'b1; cc_req_we = 1'b1; cc_req_addr = 13'h020; cc_req_wdata = 32'h1234_5678;
    cycle();
    chk("D_wr_ack", obs_g, 32'd2);
    cc_req_valid = 1'b0;
    dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = 13'h020;
    cycle();
    chk("D_rd_ack", obs_g, 32'd1);
    dma_req_valid = 1'b0;
    repeat (3) cycle();
    chk("D_valid", obs_dv, 32'd1);
    chk("D_data", obs_dd, 32'h1234_5678);

    // Cache-only write burst then read-back
    k = 0;
    for (int i = 0; i < 16; i++) begin
      cc_req_valid = 1'b1; cc_req_we = (i < 8);
      cc_req_addr = 13'h040 + 13'(i % 8); cc_req_wdata = 32'hC0DE_0000 + 32'(i);
      cycle();
      chk("F_ack", obs_g, 32'd2);
      if (obs_cv) begin chk("F_data", obs_cd, 32'hC0DE_0000 + 32'(k)); k++; end
    end
    cc_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (obs_cv) begin chk("F_data", obs_cd, 32'hC0DE_0000 + 32'(k)); k++; end
    end
    chk("F_count", k, 32'd8);

    // Random traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      if (!dma_req_valid || obs_g == 1) begin
        dma_req_valid = ($urandom_range(0, 3) != 0);
        dma_req_we    = 1'($urandom_range(0, 1));
        dma_req_addr  = 13'($urandom_range(0, 63));
        dma_req_wdata = $urandom();
      end
      if (!cc_req_valid || obs_g == 2) begin
        cc_req_valid = ($urandom_range(0, 3) != 0);
        cc_req_we    = 1'($urandom_range(0, 1));
        cc_req_addr  = 13'($urandom_range(0, 63));
        cc_req_wdata = $urandom();
      end
      rst_n = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rst_n = 1'b1; dma_req_valid = 1'b0; cc_req_valid = 1'b0;
    repeat (5) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
